// File: rtl/omp_block_a_argmax.sv
// Atom-selection stage: streams every Phi column against the residual, correlates,
// and hands the index of the largest |correlation| to the MGS stage.
module omp_block_a_argmax #(
   parameter int DATA_W = 24,
   parameter int N_COLS = 64,
   parameter int ACC_W  = 56
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start_a,
   input  logic [2:0]                  M_limit,
   input  logic [N_COLS-1:0]           sel_mask,
   output logic [$clog2(N_COLS)+2:0]   phi_addr,
   input  logic [4*DATA_W-1:0]         phi_data,
   output logic [2:0]                  r_addr,
   input  logic [4*DATA_W-1:0]         r_data,
   output logic [$clog2(N_COLS)-1:0]   lambda,
   output logic [ACC_W-1:0]            max_corr,
   output logic                        no_cand,
   output logic                        start_b,
   output logic                        done,
   output logic                        busy,
   output logic [2:0]                  state_out
);

   // state | meaning
   // IDLE  | waiting for start_a
   // SCAN  | issuing one Phi/residual address per cycle
   // DRAIN | letting the product/accumulate/compare pipeline empty
   // DONE  | one-cycle result publish, done/start_b pulse

   localparam int COL_W  = $clog2(N_COLS);
   localparam int PROD_W = 2 * DATA_W;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SCAN  = 3'd1,
      DRAIN = 3'd2,
      DONE  = 3'd3
   } state_t;

   state_t              state;
   logic [2:0]          m_lim;
   logic [N_COLS-1:0]   mask_q;
   logic [COL_W-1:0]    col;
   logic [2:0]          word;
   logic [2:0]          drain_cnt;

   logic [ACC_W-1:0]    best_abs;
   logic [COL_W-1:0]    best_idx;
   logic                found;

   // pipeline tags travelling alongside each issued address
   logic                s0_vld, s1_vld, s2_vld, s3_vld;
   logic                s0_first, s1_first, s2_first;
   logic                s0_last, s1_last, s2_last, s3_last;
   logic [COL_W-1:0]    s0_col, s1_col, s2_col, s3_col;

   logic signed [PROD_W-1:0] prod [4];
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  lane_sum;
   logic [ACC_W-1:0]         acc_abs;
   logic                     take;

   assign r_addr    = phi_addr[2:0];
   assign state_out = state;
   assign busy      = (state == SCAN) || (state == DRAIN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         m_lim     <= '0;
         mask_q    <= '0;
         col       <= '0;
         word      <= '0;
         drain_cnt <= '0;
         phi_addr  <= '0;
         s0_vld    <= 1'b0;
         s0_first  <= 1'b0;
         s0_last   <= 1'b0;
         s0_col    <= '0;
         best_abs  <= '0;
         best_idx  <= '0;
         found     <= 1'b0;
         lambda    <= '0;
         max_corr  <= '0;
         no_cand   <= 1'b0;
         start_b   <= 1'b0;
         done      <= 1'b0;
      end else begin
         s0_vld  <= 1'b0;
         start_b <= 1'b0;
         done    <= 1'b0;

         if (take) begin
            best_abs <= acc_abs;
            best_idx <= s3_col;
            found    <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (start_a) begin
                  m_lim    <= M_limit;
                  mask_q   <= sel_mask;
                  col      <= '0;
                  word     <= '0;
                  best_abs <= '0;
                  best_idx <= '0;
                  found    <= 1'b0;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               phi_addr <= {col, word};
               s0_vld   <= 1'b1;
               s0_first <= (word == 3'd0);
               s0_last  <= (word == m_lim);
               s0_col   <= col;
               if (word == m_lim) begin
                  word <= '0;
                  col  <= col + 1'b1;
                  if (col == COL_W'(N_COLS - 1)) begin
                     drain_cnt <= '0;
                     state     <= DRAIN;
                  end
               end else begin
                  word <= word + 1'b1;
               end
            end
            DRAIN: begin
               // four pipeline stages follow the last address; the final compare lands on count 4
               if (drain_cnt == 3'd4) begin
                  lambda   <= best_idx;
                  max_corr <= best_abs;
                  no_cand  <= ~found;
                  start_b  <= found;
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld   <= 1'b0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         s1_col   <= '0;
         s2_vld   <= 1'b0;
         s2_first <= 1'b0;
         s2_last  <= 1'b0;
         s2_col   <= '0;
         s3_vld   <= 1'b0;
         s3_last  <= 1'b0;
         s3_col   <= '0;
         for (int i = 0; i < 4; i++) prod[i] <= '0;
         acc      <= '0;
      end else begin
         s1_vld   <= s0_vld;
         s1_first <= s0_first;
         s1_last  <= s0_last;
         s1_col   <= s0_col;

         s2_vld   <= s1_vld;
         s2_first <= s1_first;
         s2_last  <= s1_last;
         s2_col   <= s1_col;
         for (int i = 0; i < 4; i++) begin
            prod[i] <= $signed(phi_data[DATA_W*i +: DATA_W]) * $signed(r_data[DATA_W*i +: DATA_W]);
         end

         s3_vld  <= s2_vld;
         s3_last <= s2_last;
         s3_col  <= s2_col;
         if (s2_vld) begin
            acc <= (s2_first ? '0 : acc) + lane_sum;
         end
      end
   end

   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < 4; i++) begin
         lane_sum = lane_sum + {{(ACC_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
      end
   end

   // strict greater-than keeps the lowest index on ties
   assign acc_abs = acc[ACC_W-1] ? ACC_W'(-acc) : ACC_W'(acc);
   assign take    = s3_vld && s3_last && !mask_q[s3_col]
                    && (!found || (acc_abs > best_abs));

endmodule

// File: tb/tb_omp_block_a_argmax.sv
// Directed bench for omp_block_a_argmax with behavioural Phi/residual BRAMs.
module tb_omp_block_a_argmax;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_a = 1'b0;
   logic [2:0]    M_limit = 3'd0;
   logic [63:0]   sel_mask = '0;
   logic [8:0]    phi_addr;
   logic [95:0]   phi_data;
   logic [2:0]    r_addr;
   logic [95:0]   r_data;
   logic [5:0]    lambda;
   logic [55:0]   max_corr;
   logic          no_cand, start_b, done, busy;
   logic [2:0]    state_out;

   int            n_cmp = 0;
   int            n_err = 0;
   int            phi_mode = 0;
   logic [23:0]   r_lane = 24'd1;

   omp_block_a_argmax dut (
      .clk(clk), .rst(rst), .start_a(start_a), .M_limit(M_limit), .sel_mask(sel_mask),
      .phi_addr(phi_addr), .phi_data(phi_data), .r_addr(r_addr), .r_data(r_data),
      .lambda(lambda), .max_corr(max_corr), .no_cand(no_cand), .start_b(start_b),
      .done(done), .busy(busy), .state_out(state_out)
   );

   always #5 clk = ~clk;

   // one-cycle-latency BRAM models
   always @(posedge clk) begin
      logic [23:0] pl;
      pl = (phi_mode == 0) ? {15'd0, phi_addr} : 24'd1;
      phi_data <= {4{pl}};
      r_data   <= {4{r_lane}};
   end

   task automatic run_scan(input logic [2:0] m, input logic [63:0] mask, input int retrig_at,
                           input int abort_at, input bit chk_addr, output int done_cyc,
                           output int sb_cyc, output int pulses, output int addr_err);
      done_cyc = -1; sb_cyc = -1; pulses = 0; addr_err = 0;
      @(negedge clk);
      M_limit = m; sel_mask = mask; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (int c = 1; c <= 700; c++) begin
         @(negedge clk);
         start_a = (c == retrig_at);
         if (c == abort_at) begin
            rst = 1'b1;
            return;
         end
         if (done) begin
            if (done_cyc < 0) done_cyc = c;
            pulses++;
         end
         if (start_b && sb_cyc < 0) sb_cyc = c;
         if (chk_addr && c <= 128) begin
            if (phi_addr !== 9'(((c - 1) >> 1) * 8 + ((c - 1) & 1))) addr_err++;
            if (r_addr !== 3'((c - 1) & 1)) addr_err++;
         end
         if (done_cyc > 0 && c >= done_cyc + 3) break;
      end
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if ({phi_addr, lambda, max_corr, no_cand, start_b, done, busy, state_out} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got addr=%0d lambda=%0d max=%0d nc=%b sb=%b d=%b busy=%b st=%0d, want all 0",
                  phi_addr, lambda, max_corr, no_cand, start_b, done, busy, state_out);
      end
   endtask

   task automatic test_ramp();
      int dc, sc, p, ae;
      phi_mode = 0; r_lane = 24'd1;
      run_scan(3'd7, 64'd0, 0, 0, 1'b0, dc, sc, p, ae);
      n_cmp++; if (dc !== 517) begin n_err++; $display("FAIL ramp_done_cycle: got %0d want 517", dc); end
      n_cmp++; if (sc !== 517) begin n_err++; $display("FAIL ramp_startb_cycle: got %0d want 517", sc); end
      n_cmp++; if (lambda !== 6'd63) begin n_err++; $display("FAIL ramp_lambda: got %0d want 63", lambda); end
      n_cmp++; if (max_corr !== 56'd16240) begin n_err++; $display("FAIL ramp_max: got %0d want 16240", max_corr); end
      n_cmp++; if (no_cand !== 1'b0) begin n_err++; $display("FAIL ramp_nocand: got %b want 0", no_cand); end
      n_cmp++; if (p !== 1) begin n_err++; $display("FAIL ramp_done_pulses: got %0d want 1", p); end
   endtask

   task automatic test_mask63();
      int dc, sc, p, ae;
      phi_mode = 0; r_lane = 24'd1;
      run_scan(3'd7, 64'h8000_0000_0000_0000, 0, 0, 1'b0, dc, sc, p, ae);
      n_cmp++; if (lambda !== 6'd62) begin n_err++; $display("FAIL mask63_lambda: got %0d want 62", lambda); end
      n_cmp++; if (max_corr !== 56'd15984) begin n_err++; $display("FAIL mask63_max: got %0d want 15984", max_corr); end
   endtask

   task automatic test_negative();
      int dc, sc, p, ae;
      phi_mode = 0; r_lane = 24'hFF_FFFF;
      run_scan(3'd7, 64'd0, 0, 0, 1'b0, dc, sc, p, ae);
      n_cmp++; if (lambda !== 6'd63) begin n_err++; $display("FAIL neg_lambda: got %0d want 63", lambda); end
      n_cmp++; if (max_corr !== 56'd16240) begin n_err++; $display("FAIL neg_max: got %0d want 16240", max_corr); end
      n_cmp++; if (sc !== 517) begin n_err++; $display("FAIL neg_startb_cycle: got %0d want 517", sc); end
   endtask

   task automatic test_tie_short();
      int dc, sc, p, ae;
      phi_mode = 1; r_lane = 24'd1;
      run_scan(3'd1, 64'd0, 0, 0, 1'b1, dc, sc, p, ae);
      n_cmp++; if (dc !== 133) begin n_err++; $display("FAIL tie_done_cycle: got %0d want 133", dc); end
      n_cmp++; if (lambda !== 6'd0) begin n_err++; $display("FAIL tie_lambda: got %0d want 0", lambda); end
      n_cmp++; if (max_corr !== 56'd8) begin n_err++; $display("FAIL tie_max: got %0d want 8", max_corr); end
      n_cmp++; if (ae !== 0) begin n_err++; $display("FAIL tie_addr_seq: got %0d bad addresses want 0", ae); end
   endtask

   task automatic test_all_masked();
      int dc, sc, p, ae;
      phi_mode = 0; r_lane = 24'd1;
      run_scan(3'd1, '1, 0, 0, 1'b0, dc, sc, p, ae);
      n_cmp++; if (dc !== 133) begin n_err++; $display("FAIL nocand_done_cycle: got %0d want 133", dc); end
      n_cmp++; if (sc !== -1) begin n_err++; $display("FAIL nocand_startb: got cycle %0d want never", sc); end
      n_cmp++; if (no_cand !== 1'b1) begin n_err++; $display("FAIL nocand_flag: got %b want 1", no_cand); end
      n_cmp++; if (lambda !== 6'd0) begin n_err++; $display("FAIL nocand_lambda: got %0d want 0", lambda); end
   endtask

   task automatic test_retrigger();
      int dc, sc, p, ae;
      phi_mode = 0; r_lane = 24'd1;
      run_scan(3'd7, 64'd0, 50, 0, 1'b0, dc, sc, p, ae);
      n_cmp++; if (dc !== 517) begin n_err++; $display("FAIL retrig_done_cycle: got %0d want 517", dc); end
      n_cmp++; if (p !== 1) begin n_err++; $display("FAIL retrig_pulses: got %0d want 1", p); end
      n_cmp++; if (lambda !== 6'd63) begin n_err++; $display("FAIL retrig_lambda: got %0d want 63", lambda); end
      repeat (5) @(negedge clk);
      n_cmp++;
      if (lambda !== 6'd63 || max_corr !== 56'd16240 || state_out !== 3'd0) begin
         n_err++;
         $display("FAIL result_hold: got lambda=%0d max=%0d st=%0d want 63/16240/0", lambda, max_corr, state_out);
      end
   endtask

   task automatic test_abort_restart();
      int dc, sc, p, ae, seen;
      phi_mode = 0; r_lane = 24'd1;
      run_scan(3'd7, 64'd0, 0, 200, 1'b0, dc, sc, p, ae);
      @(negedge clk);
      n_cmp++;
      if (state_out !== 3'd0 || busy !== 1'b0 || phi_addr !== 9'd0 || lambda !== 6'd0 || max_corr !== '0) begin
         n_err++;
         $display("FAIL abort_state: got st=%0d busy=%b addr=%0d lambda=%0d max=%0d want all 0",
                  state_out, busy, phi_addr, lambda, max_corr);
      end
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (done || start_b) seen++;
      end
      n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
      run_scan(3'd1, 64'd0, 0, 0, 1'b1, dc, sc, p, ae);
      n_cmp++; if (dc !== 133) begin n_err++; $display("FAIL restart_done_cycle: got %0d want 133", dc); end
      n_cmp++; if (lambda !== 6'd63) begin n_err++; $display("FAIL restart_lambda: got %0d want 63", lambda); end
      n_cmp++; if (max_corr !== 56'd4036) begin n_err++; $display("FAIL restart_max: got %0d want 4036", max_corr); end
      n_cmp++; if (ae !== 0) begin n_err++; $display("FAIL restart_addr_seq: got %0d bad addresses want 0", ae); end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_mask63();
      test_negative();
      test_tie_short();
      test_all_masked();
      test_retrigger();
      test_abort_restart();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/omp_block_a_argmax.md
# omp_block_a_argmax

Atom-selection stage of the OMP datapath, directly upstream of the MGS stage (`block_b_mgs`). On each start it streams every column of the Phi BRAM against the current residual and computes the signed correlation of each column, skipping columns already selected. It picks the column with the largest absolute correlation and hands its index (`lambda`) and the shared `M_limit` to the MGS stage with a one-cycle `start_b` pulse.

## Interface
- `DATA_W`, 24: signed element width; 4 elements are packed per 96-bit word.
- `N_COLS`, 64: number of Phi columns; the column index is 6 bits.
- `ACC_W`, 56: signed accumulator / correlation width.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_a`  in  1  start pulse; sampled only in IDLE.
- `M_limit`  in  3  words per column minus 1 (7 = 8 words / 32 rows, 1 = 2 words / 8 rows); latched at start.
- `sel_mask`  in  64  bit c = 1 excludes column c; latched at start.
- `phi_addr`  out  9  Phi BRAM address = {col[5:0], word[2:0]}.
- `phi_data`  in  96  Phi word; lane i = bits [24i+23:24i]; valid 1 cycle after its address.
- `r_addr`  out  3  residual BRAM word address, equal to `phi_addr[2:0]`.
- `r_data`  in  96  residual word, same packing and 1-cycle latency.
- `lambda`  out  6  selected column; held until the next start.
- `max_corr`  out  ACC_W  absolute correlation of `lambda`, unsigned magnitude.
- `no_cand`  out  1  1 = every column was masked.
- `start_b`  out  1  1-cycle pulse to the MGS stage; coincides with `done` unless `no_cand`.
- `done`  out  1  1-cycle pulse at the end of the scan.
- `busy`  out  1  high in SCAN and DRAIN.
- `state_out`  out  3  IDLE=0, SCAN=1, DRAIN=2, DONE=3.

## Operation
- IDLE: if `start_a`=1, latch `M_limit` and `sel_mask`, clear the best register (best_abs=0, best_idx=0, found=0), and go to SCAN.
- SCAN: issue one address per cycle in column-major order.
  - Order: col 0..63; within each column, word 0..`M_limit`.
  - `phi_addr` = col*8 + word; addresses with word > `M_limit` are never issued.
  - After the last address (col 63, word `M_limit`), go to DRAIN.
- Pipeline, relative to an address issued in cycle k:
  - k+1: data returns.
  - k+2: four 48-bit lane products are registered.
  - k+3: the lane sum is added to the accumulator; the accumulator is reset on word 0 of each column.
  - k+4: for the last word of a column, |acc| is compared with best_abs and the best register is updated.
- Update rule: replace the best when the column is unmasked AND (found=0 OR |acc| > best_abs, strictly). Ties keep the lowest index.
- DRAIN: wait until the final compare completes, then go to DONE.
- DONE, one cycle:
  - `lambda` = best_idx and `max_corr` = best_abs; `no_cand` = ~found.
  - `done`=1, `start_b` = found.
  - Return to IDLE.
- Arithmetic: signed two's complement throughout; no saturation, no rounding. With 4×8 products the width cannot overflow 56 bits. |x| is taken at full ACC_W, so the most negative value is unreachable.
- `start_a` while busy or in DONE: ignored.
- Masked columns are still fetched, which keeps the latency constant; their result is only discarded.

## Timing
- Reset values: `phi_addr`=0, `r_addr`=0, `lambda`=0, `max_corr`=0, `no_cand`=0, `start_b`=0, `done`=0, `busy`=0, `state_out`=0; state IDLE; best register cleared.
- Let cycle 0 be the rising edge that samples `start_a`=1. Then:
  - The first address (0) is driven during cycle 1.
  - The last address is driven during cycle N, where N = 64*(`M_limit`+1).
  - `done`/`start_b` are high during cycle N+5, and the block is back in IDLE at cycle N+6.
  - So latency is 133 cycles for `M_limit`=1 and 517 cycles for `M_limit`=7.
- The earliest accepted restart is `start_a` sampled in cycle N+6.
- `rst` asserted mid-scan: the next edge returns to IDLE with the reset values above. No `done` and no `start_b` are produced for the aborted scan.
- Outputs `lambda`, `max_corr` and `no_cand` are stable from DONE until the next accepted start.

## Test plan
- Phi lanes = `phi_addr` value, residual lanes = +1, `M_limit`=7, mask=0 -> `lambda`=63, `max_corr`=16240 (256c+112), `start_b` in cycle 517.
- Same stimulus, `sel_mask` bit 63 set -> `lambda`=62, `max_corr`=15984.
- Residual lanes = −1 -> magnitude wins: `lambda`=63, `max_corr`=16240.
- All Phi lanes = 1, residual = 1, `M_limit`=1 -> all columns tie -> `lambda`=0, `max_corr`=8; `done` in cycle 133; `phi_addr` sequence 0,1,8,9,…,504,505.
- `sel_mask`=all ones -> `done` pulses, `no_cand`=1, `start_b` stays 0, `lambda`=0.
- `start_a` re-pulsed at cycle 50 is ignored, with latency unchanged. `rst` at cycle 200 of a second scan -> IDLE next edge, no `done`. A fresh start then completes normally.
